// File: rtl/rst_seq_ctrl_if.sv
// Request/acknowledge and status bundle of the N-channel reset sequencer.
interface rst_seq_ctrl_if #(
  parameter int unsigned NUM_CH = 4
);
  logic              cold_req;
  logic              warm_req;
  logic [NUM_CH-1:0] ack_n;
  logic [NUM_CH-1:0] ch_rst_n;
  logic              busy;
  logic              done;
  logic              warm_pend;
  logic [NUM_CH-1:0] err_timeout;

  modport master (
    output cold_req, warm_req, ack_n,
    input  ch_rst_n, busy, done, warm_pend, err_timeout
  );

  modport slave (
    input  cold_req, warm_req, ack_n,
    output ch_rst_n, busy, done, warm_pend, err_timeout
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// N-channel cold/warm reset sequencer: assert, wait for acks with timeout,
// then release channels in ascending order separated by hold-off gaps.
module rst_seq_ctrl #(
  parameter int unsigned       NUM_CH         = 4,
  parameter logic [NUM_CH-1:0] ACK_MASK       = NUM_CH'(4'b0011),
  parameter logic [NUM_CH-1:0] WARM_MASK      = NUM_CH'(4'b1110),
  parameter int unsigned       MIN_ASSERT_CYC = 16,
  parameter int unsigned       HOLDOFF_CYC    = 8,
  parameter int unsigned       TIMEOUT_CYC    = 1024
) (
  input  logic          clk_sys,
  input  logic          rst_n_sys,
  rst_seq_ctrl_if.slave bus
);

  localparam int unsigned IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ASRT_W   = $clog2(MIN_ASSERT_CYC + 1);
  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GAP_W    = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
  localparam int unsigned GAP_LAST = (HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0;
  localparam logic [NUM_CH-1:0] ALL_CH = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_ACK,
    S_RELEASE,
    S_GAP
  } state_e;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CH-1:0] m);
    lowest_idx = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  function automatic logic [NUM_CH-1:0] above_mask(input logic [NUM_CH-1:0] m,
                                                   input logic [IDX_W-1:0]  idx);
    above_mask = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (i > int'(idx)) above_mask[i] = m[i];
    end
  endfunction

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ASRT_W-1:0]   asrt_cnt_q, asrt_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [NUM_CH-1:0]   ch_rst_n_q, ch_rst_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                warm_pend_q, warm_pend_d;
  logic [NUM_CH-1:0]   err_q, err_d;

  logic                rel_en;
  logic [IDX_W-1:0]    rel_idx;
  logic [NUM_CH-1:0]   req_mask;
  logic [NUM_CH-1:0]   missing;
  logic [NUM_CH-1:0]   rem;

  // Outputs are computed together with the state they belong to, so a
  // release and its done pulse are visible in the same cycle as RELEASE.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    asrt_cnt_d  = asrt_cnt_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ch_rst_n_d  = ch_rst_n_q;
    done_d      = 1'b0;
    warm_pend_d = warm_pend_q;
    err_d       = err_q;
    rel_en      = 1'b0;
    rel_idx     = idx_q;
    req_mask    = sel_q & ACK_MASK;
    missing     = req_mask & bus.ack_n;
    rem         = above_mask(sel_q, idx_q);

    if (bus.cold_req) begin
      state_d     = S_ASSERT;
      sel_d       = ALL_CH;
      asrt_cnt_d  = ASRT_W'(MIN_ASSERT_CYC - 1);
      to_cnt_d    = '0;
      gap_cnt_d   = '0;
      ch_rst_n_d  = '0;
      warm_pend_d = 1'b0;
    end else begin
      if (bus.warm_req && (state_q != S_IDLE)) warm_pend_d = 1'b1;

      case (state_q)
        S_IDLE: begin
          if (bus.warm_req || warm_pend_q) begin
            state_d     = S_ASSERT;
            sel_d       = WARM_MASK;
            asrt_cnt_d  = ASRT_W'(MIN_ASSERT_CYC - 1);
            ch_rst_n_d  = ch_rst_n_q & ~WARM_MASK;
            warm_pend_d = 1'b0;
          end
        end
        S_ASSERT: begin
          if (asrt_cnt_q == '0) begin
            state_d  = S_WAIT_ACK;
            to_cnt_d = '0;
          end else begin
            asrt_cnt_d = asrt_cnt_q - ASRT_W'(1);
          end
        end
        S_WAIT_ACK: begin
          if (missing == '0) begin
            rel_en  = 1'b1;
            rel_idx = lowest_idx(sel_q);
          end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            err_d   = err_q | missing;
            rel_en  = 1'b1;
            rel_idx = lowest_idx(sel_q);
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        S_RELEASE: begin
          if (rem == '0) begin
            state_d = S_IDLE;
          end else if (HOLDOFF_CYC == 0) begin
            rel_en  = 1'b1;
            rel_idx = lowest_idx(rem);
          end else begin
            state_d   = S_GAP;
            idx_d     = lowest_idx(rem);
            gap_cnt_d = '0;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
            rel_en  = 1'b1;
            rel_idx = idx_q;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase

      // An empty selection still walks RELEASE once so done fires, but
      // never touches a channel it did not assert.
      if (rel_en) begin
        state_d = S_RELEASE;
        idx_d   = rel_idx;
        if (sel_q[rel_idx]) ch_rst_n_d[rel_idx] = 1'b1;
        done_d  = (above_mask(sel_q, rel_idx) == '0);
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // Reset leaves the block mid-cold-sequence; the extra count absorbs the
  // partial cycle in which rst_n_sys is released.
  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      state_q     <= S_ASSERT;
      sel_q       <= ALL_CH;
      idx_q       <= '0;
      asrt_cnt_q  <= ASRT_W'(MIN_ASSERT_CYC);
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      ch_rst_n_q  <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      warm_pend_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      asrt_cnt_q  <= asrt_cnt_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ch_rst_n_q  <= ch_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      warm_pend_q <= warm_pend_d;
      err_q       <= err_d;
    end
  end

  assign bus.ch_rst_n    = ch_rst_n_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.warm_pend   = warm_pend_q;
  assign bus.err_timeout = err_q;

endmodule
